simplez_io_bus: RTL and testbench

//  - Memory-mapped I/O stage on the Simplez bus, downstream of the CPU's address/data/control outputs.
//  - Decodes the top four words of the 512-word map (508..511) and asserts io_sel so main memory is bypassed there.
//  - Implements a 4-bit LED port, an 8N1 serial transmitter with status, and an optional free-running timer.

---
 rtl/simplez_io_bus_pkg.sv | 24 ++
 rtl/simplez_io_bus_if.sv | 25 ++
 rtl/simplez_io_bus_uart_tx_core.sv | 70 +++++++
 rtl/simplez_io_bus.sv | 117 +++++++++++
 tb/tb_simplez_io_bus.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/simplez_io_bus_pkg.sv
// Shared constants for the Simplez memory-mapped I/O stage.
// I/O map addresses, status bit index and transmitter state type.
package simplez_io_bus_pkg;

    localparam int DATAW = 12;
    localparam int ADDRW = 9;

    localparam logic [ADDRW-1:0] IO_LEDS   = 9'd508;
    localparam logic [ADDRW-1:0] IO_STATUS = 9'd509;
    localparam logic [ADDRW-1:0] IO_TXDATA = 9'd510;
    localparam logic [ADDRW-1:0] IO_TIMER  = 9'd511;

    localparam int STATUS_TXRDY = 0;

    typedef enum logic {
        TX_IDLE,
        TX_SHIFT
    } tx_state_e;

    function automatic logic is_io(input logic [ADDRW-1:0] a);
        return a >= IO_LEDS;
    endfunction

endpackage

// File: rtl/simplez_io_bus_if.sv
// Simplez CPU-side bus into the I/O stage, plus the I/O pins it drives.
// master = CPU/testbench side, slave = I/O stage side.
interface simplez_io_bus_if;
    import simplez_io_bus_pkg::*;

    logic [ADDRW-1:0] addr;
    logic [DATAW-1:0] data_in;
    logic             wr;
    logic             rd;
    logic             io_sel;
    logic [DATAW-1:0] data_out;
    logic [3:0]       leds;
    logic             tx;

    modport master (
        output addr, data_in, wr, rd,
        input  io_sel, data_out, leds, tx
    );

    modport slave (
        input  addr, data_in, wr, rd,
        output io_sel, data_out, leds, tx
    );

endinterface

// File: rtl/simplez_io_bus_uart_tx_core.sv
// 8N1 serial transmitter: start bit, 8 data bits LSB first, stop bit.
// A start request while busy is ignored.
module uart_tx_core
    import simplez_io_bus_pkg::*;
#(
    parameter int BAUD_DIV = 104
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic [7:0] data_i,
    output logic       ready_o,
    output logic       tx_o
);

    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    tx_state_e     state_q, state_d;
    logic [9:0]    shift_q, shift_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_q, bit_d;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        unique case (state_q)
            TX_IDLE: begin
                if (start_i) begin
                    shift_d = {1'b1, data_i, 1'b0};
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = TX_SHIFT;
                end
            end
            TX_SHIFT: begin
                if (cnt_q == CW'(BAUD_DIV - 1)) begin
                    cnt_d   = '0;
                    shift_d = {1'b1, shift_q[9:1]};
                    if (bit_q == 4'd9) begin
                        state_d = TX_IDLE;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= TX_IDLE;
            shift_q <= '1;
            cnt_q   <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
        end
    end

    assign ready_o = (state_q == TX_IDLE);
    assign tx_o    = (state_q == TX_IDLE) ? 1'b1 : shift_q[0];

endmodule

// File: rtl/simplez_io_bus.sv
// Simplez I/O stage: decodes 508..511 (LEDs, TX status, TX data, timer).
// Define SIMPLEZ_IO_TIMER_EN to build the free-running timer at 511.
module simplez_io_bus
    import simplez_io_bus_pkg::*;
#(
    parameter int BAUD_DIV = 104,
    parameter int TICK_DIV = 12000
) (
    input logic             clk,
    input logic             rst,
    simplez_io_bus_if.slave bus
);

    logic             sel;
    logic             wr_io;
    logic             rd_io;
    logic             tx_start;
    logic             tx_ready;
    logic [DATAW-1:0] rdata;
    logic [DATAW-1:0] timer_rd;
    logic [3:0]       leds_q, leds_d;
    logic [DATAW-1:0] dout_q, dout_d;
    logic             unused_data;

    assign sel      = is_io(bus.addr);
    // A simultaneous write wins, so no read happens in that cycle.
    assign wr_io    = bus.wr && sel;
    assign rd_io    = bus.rd && sel && !bus.wr;
    assign tx_start = wr_io && (bus.addr == IO_TXDATA);

    assign unused_data = ^bus.data_in[DATAW-1:8];

    uart_tx_core #(
        .BAUD_DIV (BAUD_DIV)
    ) u_tx (
        .clk     (clk),
        .rst     (rst),
        .start_i (tx_start),
        .data_i  (bus.data_in[7:0]),
        .ready_o (tx_ready),
        .tx_o    (bus.tx)
    );

`ifdef SIMPLEZ_IO_TIMER_EN
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic             tmr_clr;
    logic [PW-1:0]    pre_q, pre_d;
    logic [DATAW-1:0] tmr_q, tmr_d;

    assign tmr_clr = wr_io && (bus.addr == IO_TIMER);

    always_comb begin
        pre_d = pre_q;
        tmr_d = tmr_q;
        if (tmr_clr) begin
            pre_d = '0;
            tmr_d = '0;
        end else if (pre_q == PW'(TICK_DIV - 1)) begin
            pre_d = '0;
            tmr_d = tmr_q + DATAW'(1);
        end else begin
            pre_d = pre_q + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q <= '0;
            tmr_q <= '0;
        end else begin
            pre_q <= pre_d;
            tmr_q <= tmr_d;
        end
    end

    assign timer_rd = tmr_q;
`else
    assign timer_rd = '0;
`endif

    always_comb begin
        rdata = '0;
        unique case (bus.addr)
            IO_LEDS:   rdata[3:0] = leds_q;
            IO_STATUS: rdata[STATUS_TXRDY] = tx_ready;
            IO_TIMER:  rdata = timer_rd;
            default:   rdata = '0;
        endcase
    end

    always_comb begin
        leds_d = leds_q;
        dout_d = dout_q;
        if (wr_io && (bus.addr == IO_LEDS)) begin
            leds_d = bus.data_in[3:0];
        end
        if (rd_io) begin
            dout_d = rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            leds_q <= '0;
            dout_q <= '0;
        end else begin
            leds_q <= leds_d;
            dout_q <= dout_d;
        end
    end

    assign bus.io_sel   = sel;
    assign bus.leds     = leds_q;
    assign bus.data_out = dout_q;

endmodule

// File: tb/tb_simplez_io_bus.sv
// Scoreboard bench for simplez_io_bus: randomized bus traffic against
// a cycle-stamped model of the I/O map, serial frames and timer.
module tb_simplez_io_bus;
    import simplez_io_bus_pkg::*;

    localparam int BD    = 104;
    localparam int TD    = 4;
    localparam int FRAME = 10 * BD;

    typedef struct {
        int         start;
        logic [7:0] b;
    } frame_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    simplez_io_bus_if bus ();

    simplez_io_bus #(
        .BAUD_DIV (BD),
        .TICK_DIV (TD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    frame_t      txq[$];
    logic [11:0] rdq[$];
    int          busy_until = -1000000;
    int          clr_edge = 0;
    logic [3:0]  leds_m = '0;
    logic [11:0] dout_m = '0;
    logic        fire = 1'b0;
    logic        tx_exp;
    logic [11:0] rd_exp;
    int          bitk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at edge %0d",
                     name, act, exp, cyc);
        end
    endtask

    function automatic logic [11:0] timer_m(input int m);
`ifdef SIMPLEZ_IO_TIMER_EN
        return 12'((m - 1 - clr_edge) / TD);
`else
        return 12'h000;
`endif
    endfunction

    // Reads issued at an edge are compared at the following negedge.
    always @(posedge clk) fire = bus.rd && !bus.wr && (bus.addr >= 9'd508);

    always @(negedge clk) begin
        if (fire && !rst) begin
            fire = 1'b0;
            if (rdq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rd_data: unexpected read, got %0h", bus.data_out);
            end else begin
                rd_exp = rdq.pop_front();
                check("rd_data", bus.data_out, rd_exp);
            end
        end
    end

    // Serial line: expected level computed from the frame start edge.
    always @(negedge clk) begin
        if (!rst) begin
            while (txq.size() > 0 && cyc >= txq[0].start + FRAME)
                void'(txq.pop_front());
            tx_exp = 1'b1;
            if (txq.size() > 0 && cyc >= txq[0].start) begin
                bitk = (cyc - txq[0].start) / BD;
                if (bitk == 0)
                    tx_exp = 1'b0;
                else if (bitk == 9)
                    tx_exp = 1'b1;
                else
                    tx_exp = txq[0].b[bitk-1];
            end
            check("tx", bus.tx, tx_exp);
        end
    end

    task automatic op(input logic [8:0] a, input logic [11:0] d,
                      input logic w, input logic r);
        int   n;
        logic s;
        bus.addr    = a;
        bus.data_in = d;
        bus.wr      = w;
        bus.rd      = r;
        #1;
        s = (a >= 9'd508);
        check("io_sel", bus.io_sel, s);
        n = cyc + 1;
        if (w && s) begin
            case (a)
                9'd508: leds_m = d[3:0];
                9'd510: begin
                    if (n > busy_until) begin
                        txq.push_back('{n, d[7:0]});
                        busy_until = n + FRAME;
                    end
                end
                9'd511: clr_edge = n;
                default: ;
            endcase
        end else if (r && s) begin
            case (a)
                9'd508:  dout_m = {8'h00, leds_m};
                9'd509:  dout_m = {11'h000, n > busy_until};
                9'd510:  dout_m = 12'h000;
                default: dout_m = timer_m(n);
            endcase
            rdq.push_back(dout_m);
        end
        @(negedge clk);
        bus.wr   = 1'b0;
        bus.rd   = 1'b0;
        bus.addr = '0;
        check("leds", bus.leds, leds_m);
        if (!(r && !w && s))
            check("dout_hold", bus.data_out, dout_m);
    endtask

    task automatic wait_to(input int m);
        int lim;
        lim = 0;
        while (cyc < m - 1 && lim < 50000) begin
            @(negedge clk);
            lim++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_leds", bus.leds, 4'h0);
        check("rst_tx", bus.tx, 1'b1);
        check("rst_dout", bus.data_out, 12'h000);
        txq.delete();
        rdq.delete();
        fire       = 1'b0;
        leds_m     = '0;
        dout_m     = '0;
        busy_until = -1000000;
        repeat (2) @(negedge clk);
        rst      = 1'b0;
        clr_edge = cyc;
    endtask

    initial begin
        int n0;
        int sel;
        int kind;
        logic [8:0] a;
        bus.addr    = '0;
        bus.data_in = '0;
        bus.wr      = 1'b0;
        bus.rd      = 1'b0;
        repeat (3) @(negedge clk);
        rst      = 1'b0;
        clr_edge = cyc;
        check("init_leds", bus.leds, 4'h0);
        check("init_tx", bus.tx, 1'b1);
        check("init_dout", bus.data_out, 12'h000);

        op(9'd508, 12'hFA5, 1'b1, 1'b0);
        op(9'd508, 12'h000, 1'b0, 1'b1);
        op(9'd509, 12'h000, 1'b0, 1'b1);
        op(9'd510, 12'h000, 1'b0, 1'b1);

        op(9'd510, 12'h041, 1'b1, 1'b0);
        n0 = busy_until - FRAME;
        wait_to(n0 + 500);
        op(9'd509, 12'h000, 1'b0, 1'b1);
        wait_to(n0 + FRAME);
        op(9'd509, 12'h000, 1'b0, 1'b1);
        op(9'd509, 12'h000, 1'b0, 1'b1);

        op(9'd510, 12'h055, 1'b1, 1'b0);
        repeat (9) @(negedge clk);
        op(9'd510, 12'h0AA, 1'b1, 1'b0);
        wait_to(busy_until + 2);

        op(9'd507, 12'h00C, 1'b1, 1'b0);
        op(9'd507, 12'h000, 1'b0, 1'b1);
        op(9'd000, 12'hFFF, 1'b1, 1'b1);
        op(9'd000, 12'h000, 1'b0, 1'b1);
        op(9'd508, 12'h00A, 1'b1, 1'b1);
        op(9'd508, 12'h000, 1'b0, 1'b1);

        op(9'd510, 12'h03C, 1'b1, 1'b0);
        repeat (300) @(negedge clk);
        do_reset();
        op(9'd509, 12'h000, 1'b0, 1'b1);
        op(9'd508, 12'h000, 1'b0, 1'b1);

        op(9'd511, 12'h123, 1'b1, 1'b0);
        n0 = clr_edge;
        wait_to(n0 + 41);
        op(9'd511, 12'h000, 1'b0, 1'b1);
        op(9'd511, 12'h000, 1'b1, 1'b0);
        n0 = clr_edge;
        wait_to(n0 + 4096 * TD);
        op(9'd511, 12'h000, 1'b0, 1'b1);
        wait_to(n0 + 4096 * TD + 1);
        op(9'd511, 12'h000, 1'b0, 1'b1);

        repeat (400) begin
            sel = $urandom_range(0, 9);
            if (sel < 4)
                a = 9'(508 + sel);
            else if (sel == 4)
                a = 9'd507;
            else if (sel == 5)
                a = 9'd0;
            else
                a = 9'($urandom_range(0, 511));
            kind = $urandom_range(0, 3);
            op(a, 12'($urandom), kind == 0 || kind == 2, kind != 0);
            repeat ($urandom_range(0, 30)) @(negedge clk);
            if ($urandom_range(0, 15) == 0)
                repeat (1100) @(negedge clk);
        end

        wait_to(busy_until + 4);
        repeat (4) @(negedge clk);
        check("rdq_empty", rdq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
